// File: rtl/matmult_pkg.sv
// Shared types, state encoding and result conversion for the matmult datapath.
package matmult_pkg;

  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 16;
  // Widest accumulator / result the conversion helper handles.
  localparam int ACC_MAX    = 128;
  localparam int OUT_MAX    = 64;

  typedef logic signed [DATA_W_DEF-1:0] elem_t;
  typedef elem_t [N_DEF-1:0]            vec_t;
  typedef vec_t  [N_DEF-1:0]            mat_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  // Returns {overflow, sum}; sum sits in the low out_w bits of the field.
  // Saturates to the signed out_w range when sat_mode=1, else keeps the low bits.
  function automatic logic [OUT_MAX:0] sat_convert(
    input logic signed [ACC_MAX-1:0] acc,
    input logic                      sat_mode,
    input int                        out_w
  );
    logic signed [ACC_MAX-1:0] max_v;
    logic signed [ACC_MAX-1:0] min_v;
    logic        [OUT_MAX-1:0] res;
    logic                      ovf;
    max_v = (ACC_MAX'(1) <<< (out_w - 1)) - ACC_MAX'(1);
    min_v = ~max_v;
    ovf   = 1'b1;
    if (acc > max_v) begin
      res = sat_mode ? max_v[OUT_MAX-1:0] : acc[OUT_MAX-1:0];
    end else if (acc < min_v) begin
      res = sat_mode ? min_v[OUT_MAX-1:0] : acc[OUT_MAX-1:0];
    end else begin
      ovf = 1'b0;
      res = acc[OUT_MAX-1:0];
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/dot_lane_mac.sv
// One beat of the dot product: LANES signed multiplies reduced to a single
// partial sum, sign-extended to the accumulator width.
module dot_lane_mac #(
  parameter int LANES  = 2,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic        [LANES-1:0][DATA_W-1:0] a_lanes,
  input  logic        [LANES-1:0][DATA_W-1:0] b_lanes,
  output logic signed [ACC_W-1:0]             partial
);

  logic signed [2*DATA_W-1:0] prod [LANES];

  // Full-precision signed product per lane.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = $signed(a_lanes[l]) * $signed(b_lanes[l]);
    end
  end

  // Sum of the lane products at accumulator width.
  always_comb begin
    partial = '0;
    for (int l = 0; l < LANES; l++) begin
      partial = partial + ACC_W'(prod[l]);
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// Multi-cycle signed dot product of a row vector with one column of an N x N
// matrix. Operands are captured on an accepted start, reduced LANES elements
// per cycle, and the converted result is offered on a valid/ready output.
//
// Handshakes: start is taken on a rising edge where start && start_ready.
// A result transfers on a rising edge where out_valid && out_ready; sum and
// overflow stay stable while out_valid is high and out_ready is low.
module dot_product_engine
  import matmult_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int LANES  = 2,
  parameter  int DATA_W = 16,
  parameter  int OUT_W  = 32,
  localparam int CW     = $clog2(N)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             start_ready,
  input  logic                             sat_mode,
  input  logic [CW-1:0]                    col_idx,
  input  logic [N-1:0][DATA_W-1:0]         vec_a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  mat_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_W-1:0]                 sum,
  output logic                             overflow,
  output logic                             busy,
  output state_e                           dbg_state
);

  localparam int ACC_W = 2*DATA_W + $clog2(N) + 1;
  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (N < 2 || LANES < 1 || (N % LANES) != 0) begin : g_bad_lanes
    $error("dot_product_engine: N must be >= 2 and a multiple of LANES");
  end
  if (ACC_W > ACC_MAX || OUT_W > OUT_MAX || OUT_W < 2) begin : g_bad_width
    $error("dot_product_engine: widths outside the conversion helper range");
  end

  state_e                     state_q, state_d;
  logic [N-1:0][DATA_W-1:0]   a_q, a_d, b_q, b_d, col_sel;
  logic                       sat_q, sat_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d, partial, acc_next;
  logic [BW-1:0]              beat_q, beat_d;
  logic [OUT_W-1:0]           sum_q, sum_d;
  logic                       overflow_q, overflow_d;
  logic                       out_valid_q, out_valid_d;
  logic [OUT_MAX:0]           conv;
  logic                       accept;
  logic                       unused_conv_hi;

  assign start_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept      = start & start_ready;
  assign out_valid   = out_valid_q;
  assign sum         = sum_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

  // Selected matrix column; an out-of-range index yields an all-zero column.
  always_comb begin
    col_sel = '0;
    for (int r = 0; r < N; r++) begin
      if ({1'b0, col_idx} < (CW+1)'(N)) begin
        col_sel[r] = mat_b[r][col_idx];
      end
    end
  end

  // Operands shift down by LANES elements per beat, so lanes always read the bottom.
  dot_lane_mac #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_lanes (a_q[LANES-1:0]),
    .b_lanes (b_q[LANES-1:0]),
    .partial (partial)
  );

  assign acc_next = acc_q + partial;
  assign conv     = sat_convert(ACC_MAX'(acc_next), sat_q, OUT_W);

  if (OUT_W < OUT_MAX) begin : g_conv_hi
    assign unused_conv_hi = ^conv[OUT_MAX-1:OUT_W];
  end else begin : g_conv_full
    assign unused_conv_hi = 1'b0;
  end

  // Next-state and datapath update; an accepted start overrides the state's own move.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sat_d       = sat_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    sum_d       = sum_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: ;
      ACCUM: begin
        acc_d  = acc_next;
        a_d    = a_q >> (LANES*DATA_W);
        b_d    = b_q >> (LANES*DATA_W);
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(BEATS-1)) begin
          sum_d       = conv[OUT_W-1:0];
          overflow_d  = conv[OUT_MAX];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      a_d     = vec_a;
      b_d     = col_sel;
      sat_d   = sat_mode;
      acc_d   = '0;
      beat_d  = '0;
      state_d = ACCUM;
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
      beat_q      <= '0;
      sum_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sat_q       <= sat_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      sum_q       <= sum_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
